// File: rtl/sd_block_read_sequencer.sv
// SPI-mode SD multi-block reader: one CMD17 per block, R1/token polling, payload pushed to a byte FIFO.
// Define SD_CRC16_CHECK_EN to verify the CRC-16-CCITT trailing each block.
module sd_block_read_sequencer #(
    parameter int unsigned ADDR_STEP     = 1,
    parameter int unsigned R1_TIMEOUT    = 8,
    parameter int unsigned TOKEN_TIMEOUT = 4096,
    parameter int unsigned BLOCK_BYTES   = 512
) (
    input  logic        clock,
    input  logic        reset_PB_down,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  logic [15:0] req_count,
    output logic        req_ready,
    output logic        spi_start,
    output logic [7:0]  spi_tx_byte,
    input  logic        spi_done,
    input  logic [7:0]  spi_rx_byte,
    output logic        cs,
    output logic [7:0]  fifo_data,
    output logic        fifo_push,
    input  logic        fifo_full,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code
);
    localparam int unsigned MAX_POLL = (R1_TIMEOUT > TOKEN_TIMEOUT) ? R1_TIMEOUT : TOKEN_TIMEOUT;
    localparam int unsigned MAX_CNT  = (MAX_POLL > BLOCK_BYTES) ? MAX_POLL : BLOCK_BYTES;
    localparam int unsigned CNT_W    = (MAX_CNT < 8) ? 4 : $clog2(MAX_CNT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_R1, S_TOKEN, S_DATA, S_CRC, S_GAP, S_ERR
    } state_t;

    state_t             state;
    logic [31:0]        addr;
    logic [15:0]        remaining;
    logic [CNT_W-1:0]   cnt;
    logic               pending;

`ifdef SD_CRC16_CHECK_EN
    logic [15:0]        crc;
    logic [7:0]         crc_hi;
    logic               crc_bad;

    // CRC-16-CCITT, poly 0x1021, one byte MSB first
    function automatic logic [15:0] crc16_byte(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        logic        fb;
        c = c_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction
`endif

    // CMD17 frame: opcode, 32-bit address MSB first, dummy CRC byte
    function automatic logic [7:0] cmd_byte(input logic [2:0] idx, input logic [31:0] a);
        case (idx)
            3'd0:    return 8'h51;
            3'd1:    return a[31:24];
            3'd2:    return a[23:16];
            3'd3:    return a[15:8];
            3'd4:    return a[7:0];
            default: return 8'hFF;
        endcase
    endfunction

    always_ff @(posedge clock or posedge reset_PB_down) begin
        if (reset_PB_down) begin
            state       <= S_IDLE;
            addr        <= '0;
            remaining   <= '0;
            cnt         <= '0;
            pending     <= 1'b0;
            cs          <= 1'b1;
            spi_start   <= 1'b0;
            spi_tx_byte <= 8'hFF;
            fifo_push   <= 1'b0;
            fifo_data   <= 8'h00;
            busy        <= 1'b0;
            req_ready   <= 1'b1;
            done        <= 1'b0;
            error       <= 1'b0;
            err_code    <= 2'd0;
`ifdef SD_CRC16_CHECK_EN
            crc         <= '0;
            crc_hi      <= '0;
            crc_bad     <= 1'b0;
`endif
        end else begin
            spi_start <= 1'b0;
            fifo_push <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        addr      <= req_addr;
                        remaining <= req_count;
                        err_code  <= 2'd0;
                        cnt       <= '0;
                        if (req_count == 16'd0) begin
                            done <= 1'b1;
                        end else begin
                            state     <= S_CMD;
                            cs        <= 1'b0;
                            busy      <= 1'b1;
                            req_ready <= 1'b0;
                        end
                    end
                end
                S_CMD: begin
                    if (!pending) begin
                        spi_start   <= 1'b1;
                        spi_tx_byte <= cmd_byte(cnt[2:0], addr);
                        pending     <= 1'b1;
                    end else if (spi_done) begin
                        pending <= 1'b0;
                        if (cnt == CNT_W'(5)) begin
                            cnt   <= '0;
                            state <= S_R1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                S_R1: begin
                    if (!pending) begin
                        spi_start   <= 1'b1;
                        spi_tx_byte <= 8'hFF;
                        pending     <= 1'b1;
                    end else if (spi_done) begin
                        pending <= 1'b0;
                        if (spi_rx_byte == 8'hFF) begin
                            if (cnt == CNT_W'(R1_TIMEOUT - 1)) begin
                                err_code <= 2'd1;
                                state    <= S_ERR;
                                cs       <= 1'b1;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end else if (spi_rx_byte == 8'h00) begin
                            cnt   <= '0;
                            state <= S_TOKEN;
                        end else begin
                            err_code <= 2'd2;
                            state    <= S_ERR;
                            cs       <= 1'b1;
                        end
                    end
                end
                S_TOKEN: begin
                    if (!pending) begin
                        spi_start   <= 1'b1;
                        spi_tx_byte <= 8'hFF;
                        pending     <= 1'b1;
                    end else if (spi_done) begin
                        pending <= 1'b0;
                        if (spi_rx_byte == 8'hFE) begin
                            cnt   <= '0;
                            state <= S_DATA;
`ifdef SD_CRC16_CHECK_EN
                            crc     <= '0;
                            crc_bad <= 1'b0;
`endif
                        end else if (spi_rx_byte == 8'hFF && cnt != CNT_W'(TOKEN_TIMEOUT - 1)) begin
                            cnt <= cnt + CNT_W'(1);
                        end else begin
                            err_code <= 2'd3;
                            state    <= S_ERR;
                            cs       <= 1'b1;
                        end
                    end
                end
                // a byte is only started while the FIFO has room for it
                S_DATA: begin
                    if (!pending) begin
                        if (!fifo_full) begin
                            spi_start   <= 1'b1;
                            spi_tx_byte <= 8'hFF;
                            pending     <= 1'b1;
                        end
                    end else if (spi_done) begin
                        pending   <= 1'b0;
                        fifo_data <= spi_rx_byte;
                        fifo_push <= 1'b1;
`ifdef SD_CRC16_CHECK_EN
                        crc <= crc16_byte(crc, spi_rx_byte);
`endif
                        if (cnt == CNT_W'(BLOCK_BYTES - 1)) begin
                            cnt   <= '0;
                            state <= S_CRC;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                S_CRC: begin
                    if (!pending) begin
                        spi_start   <= 1'b1;
                        spi_tx_byte <= 8'hFF;
                        pending     <= 1'b1;
                    end else if (spi_done) begin
                        pending <= 1'b0;
`ifdef SD_CRC16_CHECK_EN
                        if (cnt == '0) crc_hi <= spi_rx_byte;
                        else           crc_bad <= ({crc_hi, spi_rx_byte} != crc);
`endif
                        if (cnt == CNT_W'(1)) begin
                            cnt   <= '0;
                            state <= S_GAP;
                            cs    <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (!pending) begin
                        spi_start   <= 1'b1;
                        spi_tx_byte <= 8'hFF;
                        pending     <= 1'b1;
                    end else if (spi_done) begin
                        pending   <= 1'b0;
                        remaining <= remaining - 16'd1;
                        addr      <= addr + 32'(ADDR_STEP);
`ifdef SD_CRC16_CHECK_EN
                        if (crc_bad) begin
                            err_code  <= 2'd3;
                            error     <= 1'b1;
                            state     <= S_IDLE;
                            busy      <= 1'b0;
                            req_ready <= 1'b1;
                        end else
`endif
                        if (remaining == 16'd1) begin
                            done      <= 1'b1;
                            state     <= S_IDLE;
                            busy      <= 1'b0;
                            req_ready <= 1'b1;
                        end else begin
                            state <= S_CMD;
                            cs    <= 1'b0;
                        end
                    end
                end
                S_ERR: begin
                    if (!pending) begin
                        spi_start   <= 1'b1;
                        spi_tx_byte <= 8'hFF;
                        pending     <= 1'b1;
                    end else if (spi_done) begin
                        pending   <= 1'b0;
                        error     <= 1'b1;
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_block_read_sequencer.sv
// Randomized self-checking bench for sd_block_read_sequencer: an SD-card byte model feeds
// the SPI handshake, and a card-level reference predicts the byte streams and outcome.
`timescale 1ns/1ps
module tb_sd_block_read_sequencer;
    localparam int unsigned STEP   = 512;
    localparam int unsigned R1_TO  = 8;
    localparam int unsigned TOK_TO = 4096;
    localparam int unsigned NB     = 512;

    logic        clock = 1'b0;
    logic        reset_PB_down = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic [15:0] req_count = '0;
    logic        req_ready;
    logic        spi_start;
    logic [7:0]  spi_tx_byte;
    logic        spi_done = 1'b0;
    logic [7:0]  spi_rx_byte = 8'hFF;
    logic        cs;
    logic [7:0]  fifo_data;
    logic        fifo_push;
    logic        fifo_full = 1'b0;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;

    sd_block_read_sequencer #(.ADDR_STEP(STEP)) dut (
        .clock(clock), .reset_PB_down(reset_PB_down),
        .req_valid(req_valid), .req_addr(req_addr), .req_count(req_count), .req_ready(req_ready),
        .spi_start(spi_start), .spi_tx_byte(spi_tx_byte), .spi_done(spi_done), .spi_rx_byte(spi_rx_byte),
        .cs(cs), .fifo_data(fifo_data), .fifo_push(fifo_push), .fifo_full(fifo_full),
        .busy(busy), .done(done), .error(error), .err_code(err_code)
    );

    always #5 clock = ~clock;

    // card-side byte stream and observed DUT activity
    logic [7:0] rsp_q[$];
    logic [8:0] tx_log[$];
    logic [7:0] push_log[$];
    int         rsp_rd = 0;
    int         done_cnt = 0, err_cnt = 0, viol = 0, csl_cnt = 0;
    bit         outstanding = 1'b0;
    int unsigned wait_n = 0;
    logic       ff_at_edge = 1'b0;

    // reference expectations
    logic [8:0] exp_tx[$];
    logic [7:0] exp_push[$];
    logic [1:0] exp_err;
    int         exp_done, exp_error;

    // scenario knobs
    int         r1_ff, tok_ff;
    logic [7:0] r1_val, tok_val;
    bit         rnd_pay;
    bit         corrupt = 1'b0;

    int tx_base, push_base, done_base, err_base, viol_base, csl_base;
    int passed = 0, total = 0;

    always @(posedge clock) ff_at_edge <= fifo_full;

    // SD card byte exchange model with random latency
    always @(negedge clock) begin
        if (reset_PB_down) begin
            spi_done    = 1'b0;
            outstanding = 1'b0;
            rsp_rd      = rsp_q.size();
        end else begin
            if (spi_done) begin
                spi_done = 1'b0;
            end else if (outstanding) begin
                if (wait_n == 0) begin
                    spi_done = 1'b1;
                    if (rsp_rd < rsp_q.size()) begin
                        spi_rx_byte = rsp_q[rsp_rd];
                        rsp_rd++;
                    end else begin
                        spi_rx_byte = 8'hFF;
                    end
                    outstanding = 1'b0;
                end else begin
                    wait_n--;
                end
            end
            if (spi_start) begin
                if (outstanding || spi_done || ff_at_edge) viol++;
                outstanding = 1'b1;
                wait_n = $urandom_range(0, 2);
                tx_log.push_back({cs, spi_tx_byte});
            end
            if (fifo_push) begin
                push_log.push_back(fifo_data);
                if (fifo_full) viol++;
            end
            if (done)  done_cnt++;
            if (error) err_cnt++;
            if (!cs)   csl_cnt++;
        end
    end

`ifdef SD_CRC16_CHECK_EN
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction
`endif

    task automatic card(input logic c, input logic [7:0] t, input logic [7:0] r);
        exp_tx.push_back({c, t});
        rsp_q.push_back(r);
    endtask

    task automatic release_err(input logic [1:0] code);
        card(1'b1, 8'hFF, 8'hFF);
        exp_err   = code;
        exp_error = 1;
    endtask

    // predict card responses, transmitted bytes, pushes and outcome for one request
    task automatic plan_read(input logic [31:0] a0, input logic [15:0] n);
        logic [31:0] a;
        logic [7:0]  b;
`ifdef SD_CRC16_CHECK_EN
        logic [15:0] crc;
`endif
        exp_tx.delete();
        exp_push.delete();
        exp_err   = 2'd0;
        exp_done  = 0;
        exp_error = 0;
        for (int k = 0; k < int'(n); k++) begin
            a = a0 + 32'(k) * 32'(STEP);
            card(1'b0, 8'h51, 8'hFF);
            card(1'b0, a[31:24], 8'hFF);
            card(1'b0, a[23:16], 8'hFF);
            card(1'b0, a[15:8], 8'hFF);
            card(1'b0, a[7:0], 8'hFF);
            card(1'b0, 8'hFF, 8'hFF);
            if (r1_ff >= int'(R1_TO)) begin
                repeat (R1_TO) card(1'b0, 8'hFF, 8'hFF);
                release_err(2'd1);
                return;
            end
            repeat (r1_ff) card(1'b0, 8'hFF, 8'hFF);
            card(1'b0, 8'hFF, r1_val);
            if (r1_val != 8'h00) begin
                release_err(2'd2);
                return;
            end
            if (tok_ff >= int'(TOK_TO)) begin
                repeat (TOK_TO) card(1'b0, 8'hFF, 8'hFF);
                release_err(2'd3);
                return;
            end
            repeat (tok_ff) card(1'b0, 8'hFF, 8'hFF);
            card(1'b0, 8'hFF, tok_val);
            if (tok_val != 8'hFE) begin
                release_err(2'd3);
                return;
            end
`ifdef SD_CRC16_CHECK_EN
            crc = 16'h0000;
`endif
            for (int i = 0; i < int'(NB); i++) begin
                b = rnd_pay ? 8'($urandom) : 8'(i);
                card(1'b0, 8'hFF, b);
                exp_push.push_back(b);
`ifdef SD_CRC16_CHECK_EN
                crc = crc_step(crc, b);
`endif
            end
`ifdef SD_CRC16_CHECK_EN
            if (corrupt) crc = crc ^ 16'h0100;
            card(1'b0, 8'hFF, crc[15:8]);
            card(1'b0, 8'hFF, crc[7:0]);
            if (corrupt) begin
                release_err(2'd3);
                return;
            end
`else
            card(1'b0, 8'hFF, 8'($urandom));
            card(1'b0, 8'hFF, 8'($urandom));
`endif
            card(1'b1, 8'hFF, 8'hFF);
        end
        exp_done = 1;
    endtask

    task automatic set_knobs(input int rf, input logic [7:0] rv, input int tf, input logic [7:0] tv, input bit rp);
        r1_ff = rf; r1_val = rv; tok_ff = tf; tok_val = tv; rnd_pay = rp;
    endtask

    task automatic mark();
        tx_base = tx_log.size(); push_base = push_log.size();
        done_base = done_cnt; err_base = err_cnt; viol_base = viol; csl_base = csl_cnt;
    endtask

    task automatic issue(input logic [31:0] a, input logic [15:0] n);
        @(negedge clock); #1;
        req_addr = a; req_count = n; req_valid = 1'b1;
        @(negedge clock); #1;
        req_valid = 1'b0; req_addr = $urandom;
    endtask

    function automatic int tx_diff();
        if (tx_log.size() - tx_base != exp_tx.size()) return tx_log.size() - tx_base;
        for (int i = 0; i < exp_tx.size(); i++) if (tx_log[tx_base + i] !== exp_tx[i]) return i;
        return -1;
    endfunction

    function automatic int push_diff();
        if (push_log.size() - push_base != exp_push.size()) return push_log.size() - push_base;
        for (int i = 0; i < exp_push.size(); i++) if (push_log[push_base + i] !== exp_push[i]) return i;
        return -1;
    endfunction

    function automatic logic [17:0] got_status(input bit to);
        return {to, err_code, 4'(done_cnt - done_base), 4'(err_cnt - err_base), 4'(viol - viol_base), cs, busy, req_ready};
    endfunction

    function automatic logic [17:0] exp_status();
        return {1'b0, exp_err, 4'(exp_done), 4'(exp_error), 4'd0, 1'b1, 1'b0, 1'b1};
    endfunction

    // one request end to end; optional FIFO stall and a stray request while busy
    task automatic do_read(input logic [31:0] a, input logic [15:0] n, input int stall_at, input bit poke, output bit to);
        int  stall_left = 0;
        bit  stalled = 1'b0, poked = 1'b0;
        mark();
        plan_read(a, n);
        issue(a, n);
        to = 1'b1;
        for (int c = 0; c < 40000; c++) begin
            if (!stalled && stall_at >= 0 && push_log.size() - push_base == stall_at) begin
                fifo_full = 1'b1; stalled = 1'b1; stall_left = 20;
            end else if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) fifo_full = 1'b0;
            end
            if (poke && !poked && push_log.size() - push_base == 50) begin
                req_valid = 1'b1; req_addr = 32'h0BAD_0000; req_count = 16'd7; poked = 1'b1;
            end else begin
                req_valid = 1'b0;
            end
            if (done_cnt != done_base || err_cnt != err_base) begin
                to = 1'b0;
                break;
            end
            @(negedge clock); #1;
        end
        fifo_full = 1'b0;
        req_valid = 1'b0;
        repeat (6) @(negedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_PB_down = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        total++;
        if ({cs, busy, spi_start, spi_tx_byte, fifo_push, fifo_data, done, error, err_code, req_ready}
            !== {1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1})
            $display("FAIL reset_values: got %h need %h",
                     {cs, busy, spi_start, spi_tx_byte, fifo_push, fifo_data, done, error, err_code, req_ready},
                     {1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1});
        else passed++;
        reset_PB_down = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_single_block();
        bit to; int d;
        set_knobs(2, 8'h00, 0, 8'hFE, 1'b0);
        do_read(32'h0000_0010, 16'd1, -1, 1'b0, to);
        total++; d = tx_diff();
        if (d != -1) $display("FAIL single_block tx: diff at %0d, got %0d bytes need %0d", d, tx_log.size() - tx_base, exp_tx.size()); else passed++;
        total++; d = push_diff();
        if (d != -1) $display("FAIL single_block push: diff at %0d, got %0d pushes need %0d", d, push_log.size() - push_base, exp_push.size()); else passed++;
        total++;
        if (got_status(to) !== exp_status()) $display("FAIL single_block status: got %h need %h", got_status(to), exp_status()); else passed++;
    endtask

    task automatic test_multi_block_wrap();
        bit to; int d;
        set_knobs($urandom_range(0, 3), 8'h00, $urandom_range(0, 5), 8'hFE, 1'b1);
        do_read(32'hFFFF_FE00, 16'd3, -1, 1'b1, to);
        total++; d = tx_diff();
        if (d != -1) $display("FAIL multi_block tx: diff at %0d, got %0d bytes need %0d", d, tx_log.size() - tx_base, exp_tx.size()); else passed++;
        total++; d = push_diff();
        if (d != -1) $display("FAIL multi_block push: diff at %0d, got %0d pushes need %0d", d, push_log.size() - push_base, exp_push.size()); else passed++;
        total++;
        if (got_status(to) !== exp_status()) $display("FAIL multi_block status: got %h need %h", got_status(to), exp_status()); else passed++;
    endtask

    task automatic test_errors();
        bit to; int d;
        for (int s = 0; s < 3; s++) begin
            case (s)
                0:       set_knobs(int'(R1_TO), 8'h00, 0, 8'hFE, 1'b1);
                1:       set_knobs($urandom_range(0, 3), 8'h05, 0, 8'hFE, 1'b1);
                default: set_knobs($urandom_range(0, 3), 8'h00, $urandom_range(0, 4), 8'h0D, 1'b1);
            endcase
            do_read($urandom, 16'd2, -1, 1'b0, to);
            total++; d = tx_diff();
            if (d != -1) $display("FAIL error_case%0d tx: diff at %0d, got %0d bytes need %0d", s, d, tx_log.size() - tx_base, exp_tx.size()); else passed++;
            total++;
            if (push_log.size() - push_base !== 0) $display("FAIL error_case%0d push: got %0d pushes need 0", s, push_log.size() - push_base); else passed++;
            total++;
            if (got_status(to) !== exp_status()) $display("FAIL error_case%0d status: got %h need %h", s, got_status(to), exp_status()); else passed++;
        end
    endtask

    task automatic test_zero_count();
        bit to;
        set_knobs(0, 8'h00, 0, 8'hFE, 1'b0);
        do_read(32'h1234_5678, 16'd0, -1, 1'b0, to);
        total++;
        if (tx_log.size() - tx_base !== 0 || csl_cnt !== csl_base)
            $display("FAIL zero_count bus: got %0d bytes, %0d cs-low cycles, need 0 and 0", tx_log.size() - tx_base, csl_cnt - csl_base);
        else passed++;
        total++;
        if (got_status(to) !== exp_status()) $display("FAIL zero_count status: got %h need %h", got_status(to), exp_status()); else passed++;
    endtask

    task automatic test_fifo_stall();
        bit to; int d;
        set_knobs(1, 8'h00, 2, 8'hFE, 1'b1);
        do_read($urandom, 16'd1, 100, 1'b0, to);
        total++; d = push_diff();
        if (d != -1) $display("FAIL fifo_stall push: diff at %0d, got %0d pushes need %0d", d, push_log.size() - push_base, exp_push.size()); else passed++;
        total++;
        if (got_status(to) !== exp_status()) $display("FAIL fifo_stall status: got %h need %h", got_status(to), exp_status()); else passed++;
    endtask

    task automatic test_reset_mid_data();
        bit to; int d;
        set_knobs(1, 8'h00, 1, 8'hFE, 1'b1);
        mark();
        plan_read(32'h0000_2000, 16'd2);
        issue(32'h0000_2000, 16'd2);
        to = 1'b1;
        for (int c = 0; c < 20000; c++) begin
            if (push_log.size() - push_base >= 300) begin
                to = 1'b0;
                break;
            end
            @(negedge clock); #1;
        end
        reset_PB_down = 1'b1;
        #1;
        total++;
        if ({to, cs, busy, spi_start, spi_tx_byte, fifo_push, fifo_data, done, error, err_code, req_ready}
            !== {1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1})
            $display("FAIL reset_mid_data: got %h need %h",
                     {to, cs, busy, spi_start, spi_tx_byte, fifo_push, fifo_data, done, error, err_code, req_ready},
                     {1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1});
        else passed++;
        repeat (3) @(negedge clock);
        #1;
        reset_PB_down = 1'b0;
        do_read(32'h0000_0040, 16'd1, -1, 1'b0, to);
        total++; d = push_diff();
        if (d != -1) $display("FAIL after_reset push: diff at %0d, got %0d pushes need %0d", d, push_log.size() - push_base, exp_push.size()); else passed++;
        total++;
        if (got_status(to) !== exp_status()) $display("FAIL after_reset status: got %h need %h", got_status(to), exp_status()); else passed++;
    endtask

    task automatic test_random();
        bit to; int d; int pick;
        for (int it = 0; it < 3; it++) begin
            pick = $urandom_range(0, 3);
            case (pick)
                2:       set_knobs($urandom_range(0, 3), 8'($urandom_range(1, 254)), 0, 8'hFE, 1'b1);
                3:       set_knobs($urandom_range(0, 3), 8'h00, $urandom_range(0, 6), 8'($urandom_range(0, 253)), 1'b1);
                default: set_knobs($urandom_range(0, 7), 8'h00, $urandom_range(0, 6), 8'hFE, 1'b1);
            endcase
            do_read($urandom, 16'($urandom_range(1, 2)), -1, 1'b0, to);
            total++; d = tx_diff();
            if (d != -1) $display("FAIL random%0d tx: diff at %0d, got %0d bytes need %0d", it, d, tx_log.size() - tx_base, exp_tx.size()); else passed++;
            total++; d = push_diff();
            if (d != -1) $display("FAIL random%0d push: diff at %0d, got %0d pushes need %0d", it, d, push_log.size() - push_base, exp_push.size()); else passed++;
            total++;
            if (got_status(to) !== exp_status()) $display("FAIL random%0d status: got %h need %h", it, got_status(to), exp_status()); else passed++;
        end
    endtask

`ifdef SD_CRC16_CHECK_EN
    task automatic test_crc_mismatch();
        bit to; int d;
        set_knobs(0, 8'h00, 0, 8'hFE, 1'b1);
        corrupt = 1'b1;
        do_read(32'h0000_0100, 16'd2, -1, 1'b0, to);
        corrupt = 1'b0;
        total++; d = tx_diff();
        if (d != -1) $display("FAIL crc_mismatch tx: diff at %0d, got %0d bytes need %0d", d, tx_log.size() - tx_base, exp_tx.size()); else passed++;
        total++;
        if (got_status(to) !== exp_status()) $display("FAIL crc_mismatch status: got %h need %h", got_status(to), exp_status()); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_single_block();
        test_multi_block_wrap();
        test_errors();
        test_zero_count();
        test_fifo_stall();
        test_reset_mid_data();
        test_random();
`ifdef SD_CRC16_CHECK_EN
        test_crc_mismatch();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
